cross_handshake_arb: RTL
========================

Name: cross_handshake_arb

Overview:
- Round-robin arbiter that shares one cross_handshake channel among NUM_REQ requesters in the source clock domain.
- Registers the winning requester's word and tags it with the requester index.
- Drives the channel's din/din_valid, then waits for the returned din_ack before serving the next requester.
- Adds a stuck-ack watchdog and a transfer counter for debug.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 32, payload width per requester
ID_W, 2, tag width; must satisfy 2^ID_W >= NUM_REQ
TMO_W, 10, watchdog counter width; timeout fires after 2^TMO_W-1 cycles in WAIT_ACK
CNT_W, 16, transfer counter width

Ports:
clk  in  1  source-domain clock; same clock as the channel's din_clk
srst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request; held until its req_ack
req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]; stable while req_valid is high
req_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
xh_din  out  ID_W+DATA_W  {tag, payload} to channel din
xh_din_valid  out  1  to channel din_valid
xh_din_ack  in  1  channel din_ack pulse
busy  out  1  high in any state other than IDLE
grant_id  out  ID_W  index of the current or last granted requester
timeout_flag  out  1  sticky; set by the watchdog
xfer_count  out  CNT_W  completed transfers, wraps modulo 2^CNT_W

Behaviour:
- Reset values: req_ack=0, xh_din=0, xh_din_valid=0, busy=0, grant_id=0, timeout_flag=0, xfer_count=0.
- Reset state: state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 has first priority.

States:
- IDLE:
  - If any req_valid is set, pick the first requester at or after index (rr_ptr+1) mod NUM_REQ, searching upward with wrap.
  - Register xh_din <= {index, req_data[index]} and grant_id <= index; go to LAUNCH.
  - No request: stay in IDLE.
- LAUNCH:
  - xh_din_valid=1 for exactly this one cycle; clear the watchdog; go to WAIT_ACK.
  - The single-cycle valid is mandatory. The channel relaunches if valid is still high when it frees, so the arbiter never holds valid.
- WAIT_ACK:
  - xh_din_valid=0 and xh_din stays stable.
  - The watchdog increments each cycle.
  - On xh_din_ack, go to DONE.
  - On watchdog saturation, set timeout_flag and keep waiting. There is no abort, because the channel cannot be un-launched.
- DONE:
  - req_ack[grant_id]=1 for this cycle; rr_ptr <= grant_id; xfer_count += 1; go to IDLE.

Latency and rules:
- Request sampled in IDLE at cycle n: xh_din_valid is high in cycle n+1.
- Ack seen in cycle m: req_ack is high in cycle m+1; the next grant is decided in cycle m+2 at the earliest.
- Requesters drop or update req_valid on the edge at which they sample req_ack high. The arbiter never re-grants a requester in the IDLE cycle immediately after its DONE unless its req_valid is still high.
- A requester that withdraws before it is granted is simply skipped. The payload is captured at grant, so req_data may change after the IDLE→LAUNCH edge.
- xh_din_ack outside WAIT_ACK (a late ack after srst) is ignored; no req_ack and no count.
- xh_din_ack in the same cycle as watchdog saturation: the ack wins and timeout_flag is still set.
- srst at any time: immediate return to IDLE with all outputs at reset values; an in-flight word is abandoned.
- At system level the channel and this block are reset or quiesced together.
- xfer_count wraps from 2^CNT_W-1 to 0.
- Out-of-range indices (NUM_REQ < 2^ID_W) are never granted.

Decomposition:
- Shared package: state encoding (IDLE=0, LAUNCH=1, WAIT_ACK=2, DONE=3) and the ID_W derivation helper (clog2, minimum 1).
- One natural sub-module: rr_pick, combinational. Inputs are the request vector and pointer; outputs are the grant index and an any-request flag. It can be reused by other channel arbiters.

Test Plan:
- Single request: req_valid=0001 with data 0xA5A5A5A5. Expect xh_din={2'd0,0xA5A5A5A5} with a one-cycle valid one cycle later. Ack returned 5 cycles after that; req_ack=0001 pulses the next cycle; xfer_count=1.
- All four requesting continuously with immediate acks: grant order 0,1,2,3,0. Each req_ack is exactly one cycle. No two valid pulses occur without an intervening ack.
- Fairness: requesters 1 and 3 continuously active, rr_ptr=1 after a grant. Expect alternation 3,1,3,1 with no starvation over 100 transfers.
- Ack withheld 1100 cycles with TMO_W=10: timeout_flag rises at cycle 1023 of WAIT_ACK. The ack is then accepted and req_ack pulses; timeout_flag stays 1 until srst.
- srst asserted in WAIT_ACK, then a late xh_din_ack: all outputs reset, no req_ack, xfer_count=0. The next request is granted normally starting from requester 0.
- Stray xh_din_ack in IDLE plus a request withdrawn before grant: no req_ack, no count change, and the withdrawn requester is never launched.

Source files
------------

// File: rtl/cross_handshake_arb_pkg.sv
// Shared types for the cross_handshake channel arbiter: FSM encoding and
// tag-width derivation.
package cross_handshake_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Tag width needed to name n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cross_handshake_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr,
// searching upward with wrap. Reusable by other channel arbiters.
module cross_handshake_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    always_comb begin : pick
        int              w_pos;
        logic [ID_W-1:0] w_idx;
        o_idx = '0;
        w_pos = 0;
        w_idx = '0;
        // Walk from farthest to nearest so the nearest hit is written last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = (int'(i_ptr) + k) % NUM_REQ;
            w_idx = ID_W'(w_pos);
            if (i_req[w_idx]) begin
                o_idx = w_idx;
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/cross_handshake_arb.sv
// Round-robin arbiter sharing one cross_handshake channel among NUM_REQ
// requesters: one-cycle launch, wait for din_ack, then acknowledge the winner.
module cross_handshake_arb
    import cross_handshake_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = id_width(NUM_REQ),
    parameter int TMO_W   = 10,
    parameter int CNT_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_srst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ack,
    output logic [ID_W+DATA_W-1:0]    o_xh_din,
    output logic                      o_xh_din_valid,
    input  logic                      i_xh_din_ack,
    output logic                      o_busy,
    output logic [ID_W-1:0]           o_grant_id,
    output logic                      o_timeout_flag,
    output logic [CNT_W-1:0]          o_xfer_count
);

    localparam logic [TMO_W-1:0] TMO_SAT = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] TMO_PRE = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ID_W-1:0]          r_rr_ptr;
    logic [ID_W-1:0]          r_grant;
    logic [ID_W+DATA_W-1:0]   r_din;
    logic [TMO_W-1:0]         r_wdog;
    logic                     r_timeout;
    logic [CNT_W-1:0]         r_count;
    logic [ID_W-1:0]          w_pick_idx;
    logic                     w_pick_any;
    logic [DATA_W-1:0]        w_pick_data;

    cross_handshake_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req (i_req_valid),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_pick_data = i_req_data[int'(w_pick_idx)*DATA_W +: DATA_W];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_pick_any) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH:   w_state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: if (i_xh_din_ack) w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_rr_ptr  <= ID_W'(NUM_REQ - 1);
            r_grant   <= '0;
            r_din     <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_din   <= {w_pick_idx, w_pick_data};
                        r_grant <= w_pick_idx;
                    end
                end
                ST_LAUNCH: r_wdog <= '0;
                ST_WAIT_ACK: begin
                    // The channel cannot be un-launched, so saturation only flags.
                    if (r_wdog != TMO_SAT) begin
                        r_wdog <= r_wdog + 1'b1;
                        if (r_wdog == TMO_PRE) r_timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_rr_ptr <= r_grant;
                    r_count  <= r_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ack
        assign o_req_ack[g] = (r_state == ST_DONE) && (r_grant == ID_W'(g));
    end

    assign o_xh_din       = r_din;
    assign o_xh_din_valid = (r_state == ST_LAUNCH);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_grant_id     = r_grant;
    assign o_timeout_flag = r_timeout;
    assign o_xfer_count   = r_count;

endmodule
